// File: rtl/fifo_level_pkg.sv
// rtl/fifo_level_pkg.sv - shared types and helpers for the fifo_level buffer
package fifo_level_pkg;

  // How the head word reaches read_data_o.
  typedef enum logic {
    READ_STANDARD = 1'b0,
    READ_FWFT     = 1'b1
  } read_mode_e;

  // Sticky error flags kept together so they reset and clear as one unit.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } error_flags_t;

  localparam error_flags_t ERRORS_NONE = '{overflow: 1'b0, underflow: 1'b0};

  // Sticky flag update: a new event in the same cycle as a clear keeps the flag set.
  function automatic logic sticky_next(input logic flag, input logic set, input logic clear);
    return set | (flag & ~clear);
  endfunction

  // Map the integer FWFT parameter onto the read mode.
  function automatic read_mode_e read_mode(input int fwft);
    return (fwft != 0) ? READ_FWFT : READ_STANDARD;
  endfunction

endpackage

// File: rtl/fifo_level_ram.sv
// rtl/fifo_level_ram.sv - storage array with one synchronous write and one asynchronous read port
module fifo_level_ram #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 2
) (
  input  logic                 clock,
  input  logic                 write_en,
  input  logic [ADDR_BITS-1:0] write_addr,
  input  logic [DATA_BITS-1:0] write_data,
  input  logic [ADDR_BITS-1:0] read_addr,
  output logic [DATA_BITS-1:0] read_data
);

  localparam int ENTRIES = 1 << ADDR_BITS;

  // Contents are deliberately not reset; the pointers define what is valid.
  logic [DATA_BITS-1:0] mem [ENTRIES];

  // Write port: one word per cycle at the write pointer.
  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/fifo_level.sv
// rtl/fifo_level.sv - synchronous FIFO with level, thresholds, FWFT option, flush and sticky errors
module fifo_level
  import fifo_level_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int DEPTH_BITS   = 2,
  parameter int FWFT         = 0,
  parameter int ALMOST_FULL  = (1 << DEPTH_BITS) - 1,
  parameter int ALMOST_EMPTY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  write_i,
  input  logic [DATA_BITS-1:0]  write_data_i,
  output logic                  write_ready_o,
  input  logic                  read_i,
  output logic [DATA_BITS-1:0]  read_data_o,
  output logic                  read_ready_o,
  output logic [DEPTH_BITS:0]   level_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  input  logic                  error_clear_i,
  output logic                  error_overflow_o,
  output logic                  error_underflow_o
);

  localparam int         DEPTH    = 1 << DEPTH_BITS;
  localparam int         PTR_BITS = DEPTH_BITS + 1;
  localparam read_mode_e MODE     = read_mode(FWFT);

  localparam logic [PTR_BITS-1:0] PTR_ONE    = PTR_BITS'(1);
  localparam logic [PTR_BITS-1:0] LEVEL_FULL = PTR_BITS'(DEPTH);
  localparam logic [PTR_BITS-1:0] LEVEL_AF   = PTR_BITS'(ALMOST_FULL);
  localparam logic [PTR_BITS-1:0] LEVEL_AE   = PTR_BITS'(ALMOST_EMPTY);

  // Elaboration-time parameter legality checks.
  if (DATA_BITS < 1) begin : g_bad_data_bits
    $error("fifo_level: DATA_BITS must be at least 1");
  end
  if (DEPTH_BITS < 1) begin : g_bad_depth_bits
    $error("fifo_level: DEPTH_BITS must be at least 1");
  end
  if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_almost_full
    $error("fifo_level: ALMOST_FULL must lie in 1..DEPTH");
  end
  if (ALMOST_EMPTY < 0 || ALMOST_EMPTY > DEPTH - 1) begin : g_bad_almost_empty
    $error("fifo_level: ALMOST_EMPTY must lie in 0..DEPTH-1");
  end

  // One extra pointer bit tells full (level DEPTH) apart from empty (level 0).
  logic [PTR_BITS-1:0]  read_ptr;
  logic [PTR_BITS-1:0]  write_ptr;
  logic [PTR_BITS-1:0]  level;

  logic                 pop_ok;
  logic                 push_ok;
  logic                 do_pop;
  logic                 do_push;
  logic                 overflow_set;
  logic                 underflow_set;
  error_flags_t         errors;
  logic [DATA_BITS-1:0] head_data;

  // Status decodes use registered pointers only, so they never depend on this cycle's requests.
  always_comb begin
    level          = write_ptr - read_ptr;
    write_ready_o  = (level != LEVEL_FULL);
    read_ready_o   = (level != '0);
    almost_full_o  = (level >= LEVEL_AF);
    almost_empty_o = (level <= LEVEL_AE);
  end

  assign level_o = level;

  // Request qualification: a pop frees a slot for a same-cycle push when full,
  // but a push never feeds a same-cycle pop when empty. Flush drops both silently.
  always_comb begin
    pop_ok        = read_i & read_ready_o;
    push_ok       = write_i & (write_ready_o | pop_ok);
    do_pop        = pop_ok & ~flush_i;
    do_push       = push_ok & ~flush_i;
    overflow_set  = write_i & ~push_ok & ~flush_i;
    underflow_set = read_i & ~read_ready_o & ~flush_i;
  end

  // Pointer registers: reset beats flush, flush beats traffic.
  always_ff @(posedge clock) begin
    if (!reset) begin
      read_ptr  <= '0;
      write_ptr <= '0;
    end else if (flush_i) begin
      read_ptr  <= '0;
      write_ptr <= '0;
    end else begin
      if (do_push) begin
        write_ptr <= write_ptr + PTR_ONE;
      end
      if (do_pop) begin
        read_ptr <= read_ptr + PTR_ONE;
      end
    end
  end

  // Sticky error flags; a flush neither sets nor clears them beyond an explicit clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      errors <= ERRORS_NONE;
    end else begin
      errors.overflow  <= sticky_next(errors.overflow, overflow_set, error_clear_i);
      errors.underflow <= sticky_next(errors.underflow, underflow_set, error_clear_i);
    end
  end

  assign error_overflow_o  = errors.overflow;
  assign error_underflow_o = errors.underflow;

  fifo_level_ram #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (DEPTH_BITS)
  ) u_ram (
    .clock      (clock),
    .write_en   (do_push),
    .write_addr (write_ptr[DEPTH_BITS-1:0]),
    .write_data (write_data_i),
    .read_addr  (read_ptr[DEPTH_BITS-1:0]),
    .read_data  (head_data)
  );

  if (MODE == READ_FWFT) begin : g_fwft
    assign read_data_o = head_data;
  end else begin : g_standard
    logic [DATA_BITS-1:0] read_data_q;

    // Registered read: capture the head word on each accepted pop, hold otherwise.
    always_ff @(posedge clock) begin
      if (!reset) begin
        read_data_q <= '0;
      end else if (do_pop) begin
        read_data_q <= head_data;
      end
    end

    assign read_data_o = read_data_q;
  end

endmodule
